// File: rtl/multicycle_core.sv
// multicycle_core: multicycle MIPS-subset CPU sharing one ALU and one unified memory.
// Defining MULTICYCLE_PERF_EN adds the cycle and retired-instruction counters.
module multicycle_core #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         prog_we,
    input  logic [$clog2(MEM_WORDS)-1:0] prog_addr,
    input  logic [31:0]                  prog_data,
    input  logic [4:0]                   observe,
    output logic [31:0]                  data_ob,
    output logic [31:0]                  pc_ob,
    output logic [3:0]                   state_ob,
    output logic                         halted,
    output logic [31:0]                  cycle_cnt,
    output logic [31:0]                  instr_cnt
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd15
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] aluout_q, aluout_d;
    logic [31:0] rf_q [32];
    logic [31:0] mem [MEM_WORDS];

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        mem_we;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] sext_imm;

    logic [31:0] instr_word;
    logic [31:0] data_word;

    alu_op_e     alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        alu_zero;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};

    // Both read ports wrap modulo the memory depth; the byte offset is dropped.
    assign instr_word = mem[pc_q[AW+1:2]];
    assign data_word  = mem[aluout_q[AW+1:2]];

    function automatic logic funct_legal(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_SLT);
    endfunction

    // Operand selection for the single shared ALU, driven purely by state.
    always_comb begin
        alu_a  = pc_q;
        alu_b  = 32'd4;
        alu_op = ALU_ADD;
        case (state_q)
            S_DECODE: alu_b = {sext_imm[29:0], 2'b00};
            S_MEMADR, S_ADDIEX: begin
                alu_a = a_q;
                alu_b = sext_imm;
            end
            S_EXEC: begin
                alu_a = a_q;
                alu_b = b_q;
                case (funct)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_BRANCH: begin
                alu_a  = a_q;
                alu_b  = b_q;
                alu_op = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_y = '0;
        case (alu_op)
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = '0;
        endcase
    end

    assign alu_zero = (alu_y == 32'd0);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mdr_d    = mdr_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = aluout_q;
        mem_we   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = instr_word;
                pc_d    = alu_y;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d      = rf_q[rs];
                b_d      = rf_q[rt];
                aluout_d = alu_y;
                case (opcode)
                    OP_RTYPE:     state_d = funct_legal(funct) ? S_EXEC : S_HALT;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                aluout_d = alu_y;
                state_d  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mdr_d   = data_word;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                rf_we    = 1'b1;
                rf_wdata = mdr_q;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                mem_we  = 1'b1;
                state_d = S_FETCH;
            end
            S_EXEC: begin
                aluout_d = alu_y;
                state_d  = S_RWB;
            end
            S_RWB: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                // Opcode here is beq or bne: take when the zero flag matches beq-ness.
                if ((opcode == OP_BEQ) == alu_zero) pc_d = aluout_q;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                aluout_d = alu_y;
                state_d  = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            if (rf_we && (rf_waddr != 5'd0)) rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // Memory keeps its contents across reset; loading is only possible while in reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            if (prog_we) mem[prog_addr] <= prog_data;
        end else if (mem_we) begin
            mem[aluout_q[AW+1:2]] <= b_q;
        end
    end

    assign data_ob  = reset ? 32'd0 : rf_q[observe];
    assign pc_ob    = pc_q;
    assign state_ob = state_q;
    assign halted   = (state_q == S_HALT);

`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cycle_q;
    logic [31:0] instr_q;
    logic        instr_done;

    // Every completing state returns to FETCH, and FETCH never loops to itself.
    assign instr_done = (state_d == S_FETCH);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else if (state_q != S_HALT) begin
            cycle_q <= cycle_q + 32'd1;
            if (instr_done) instr_q <= instr_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`else
    assign cycle_cnt = 32'd0;
    assign instr_cnt = 32'd0;
`endif

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multicycle MIPS-subset processor: the next generation of the single-cycle core top. Executes one instruction over 3–5 clock edges under a Moore control FSM, sharing one ALU and one unified instruction/data memory instead of separate IM/dataMem and adders. Adds program load, debug observe ports, a halt state and optional performance counters.

## Interface
- `MEM_WORDS`, 256 — unified memory depth in 32-bit words; power of two, 16..4096.
- `RESET_PC`, 32'h0000_0000 — PC value loaded on reset.
- `CLK`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — asynchronous, active-high.
  - Clears PC to `RESET_PC`, FSM to FETCH, all 32 registers to 0, `halted` to 0.
  - Memory contents are retained.
- `prog_we`  in  1  — memory write strobe for program/data load. Honoured only while `reset` is high.
- `prog_addr`  in  log2(MEM_WORDS)  — word address for `prog_we`.
- `prog_data`  in  32  — word written at `prog_addr`.
- `observe`  in  5  — register index to expose.
- `data_ob`  out  32  — combinational value of register[`observe`]; 0 during reset.
- `pc_ob`  out  32  — current PC; `RESET_PC` during reset.
- `state_ob`  out  4  — FSM state encoding; FETCH (0) during reset.
- `halted`  out  1  — high in HALT; 0 after reset.
- `cycle_cnt`  out  32  — see Configuration.
- `instr_cnt`  out  32  — see Configuration.

## Operation
- **Supported instructions:**
  - R-type (op 0): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, addi 0x08.
- **Illegal encodings:** any other opcode, or an R-type with any other funct, goes to HALT.
- **Internal registers:** IR, MDR, A, B, ALUOut. Each is written only in the states listed below.
- **FSM states** (state_ob encoding):
  - FETCH=0: IR←mem[PC]; PC←PC+4.
  - DECODE=1: A←rs; B←rt; ALUOut←PC+(sext(imm)<<2). Dispatches on opcode.
  - MEMADR=2: ALUOut←A+sext(imm). Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD=3: MDR←mem[ALUOut] → MEMWB=4: rt←MDR → FETCH.
  - MEMWR=5: mem[ALUOut]←B → FETCH.
  - EXEC=6: ALUOut←A op B → RWB=7: rd←ALUOut → FETCH.
  - BRANCH=8: compare A, B. If (A==B) for beq, or (A!=B) for bne, PC←ALUOut → FETCH.
  - JUMP=9: PC←{PC[31:28], IR[25:0], 2'b00} → FETCH.
  - ADDIEX=10: ALUOut←A+sext(imm) → ADDIWB=11: rt←ALUOut → FETCH.
  - HALT=15: no state changes; exits only via reset.
- **Cycles per instruction:** lw 5; sw, R-type, addi 4; beq, bne, j 3.
- **Arithmetic:**
  - 32-bit two's complement; overflow is ignored (no trap).
  - slt is a signed compare.
  - sext replicates imm[15].
- **Register 0:** writes are discarded; it always reads 0.
- **Memory addressing:**
  - Word index = addr[log2(MEM_WORDS)+1:2].
  - Upper address bits wrap (modulo depth).
  - addr[1:0] is ignored.
- **Memory timing:** synchronous write; combinational read.
- **Fetch after PC wrap:** fetch continues from index 0.

## Timing
- State and all architectural updates occur on the rising edge of CLK.
- Register write-back (MEMWB, RWB, ADDIWB) is visible on `data_ob` in the cycle after the write-back edge.
- `pc_ob` changes on the FETCH edge, or on the BRANCH/JUMP edge when the branch or jump is taken.
- Reset asserted mid-instruction aborts the instruction with no partial register or memory write; the FSM is in FETCH on the first edge after deassertion.
- `prog_we` with `reset` low is ignored.
- Simultaneous `prog_we` and `reset`: the write completes on the CLK edge.
- A load immediately followed by a dependent instruction needs no interlock; the multicycle sequencing guarantees ordering.

## Configuration
- **`MULTICYCLE_PERF_EN` defined:**
  - `cycle_cnt` increments every CLK edge while not reset and not halted.
  - `instr_cnt` increments on each transition into FETCH from a completing state.
  - Both counters clear on reset and wrap at 2^32.
  - In HALT both counters freeze.
- **`MULTICYCLE_PERF_EN` undefined:**
  - Counter logic is omitted.
  - `cycle_cnt` and `instr_cnt` are tied to 0; ports remain present.

## Test plan
- **Load and add:** load addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 at words 0–2, release reset → after 12 cycles, observe=3 gives data_ob=12 and pc_ob=0x0C.
- **Memory round trip:** sw $3,8($0) then lw $4,8($0) → mem word 2 = 12; observe=4 gives 12; lw takes exactly 5 cycles (state_ob sequence 0,1,2,3,4).
- **Branches:**
  - beq $1,$1,+2 at PC 0x10 → pc_ob=0x1C after 3 cycles.
  - bne $1,$1,+2 → pc_ob=0x14.
  - Negative offset −1 at 0x20 → pc_ob=0x20 (loop).
- **Jump and $0:**
  - j 0x40 → pc_ob=0x100.
  - addi $0,$0,9 → observe=0 gives 0.
  - slt with $1=−1, $2=1 → rd gets 1.
- **Halt and reset:**
  - Opcode 0x3F → halted=1 and state_ob=15; pc_ob stable for 20 cycles.
  - Asserting reset mid-lw (in MEMRD) → no register write, pc_ob=RESET_PC, halted=0.
- **Perf:** with `MULTICYCLE_PERF_EN`, the three-instruction add program gives cycle_cnt=12 and instr_cnt=3; without it, both read 0.
